// File: rtl/prm_pkg.sv
// Shared definitions for the prm skid buffer: FSM state encodings and the
// state-to-occupancy mapping.
package prm_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  function automatic logic [1:0] state_count(input state_t s);
    logic [1:0] c;
    c = 2'd0;
    case (s)
      ST_FULL: c = 2'd1;
      ST_SKID: c = 2'd2;
      default: c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/prm_register_sce.sv
// Payload register with synchronous active-low reset and clear (clear wins
// over write enable).
module prm_register_sce #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_n,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (!clr_n) begin
      r_q <= '0;
    end else if (we) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/prm_skid_buffer.sv
// Two-entry skid buffer: registered output stage plus a skid slot so that
// in_ready never depends combinationally on out_ready.
//
//   state    | meaning
//   ---------+---------------------------------------------
//   ST_EMPTY | nothing buffered, count 0
//   ST_FULL  | main register valid, count 1
//   ST_SKID  | main and skid valid, upstream stalled, count 2
module prm_skid_buffer
  import prm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_in_xfer;
  logic             w_out_xfer;
  logic             w_main_we;
  logic             w_skid_we;
  logic [WIDTH-1:0] w_main_d;
  logic [WIDTH-1:0] w_main_q;
  logic [WIDTH-1:0] w_skid_q;

  assign in_ready   = (r_state != ST_SKID) && rst_n && clr_n;
  assign out_valid  = (r_state == ST_FULL) || (r_state == ST_SKID);
  assign w_in_xfer  = in_valid && in_ready;
  assign w_out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_main_we   = 1'b0;
    w_skid_we   = 1'b0;
    w_main_d    = in_data;
    case (r_state)
      ST_EMPTY: begin
        if (w_in_xfer) begin
          w_main_we   = 1'b1;
          w_state_nxt = ST_FULL;
        end
      end
      ST_FULL: begin
        if (w_in_xfer && w_out_xfer) begin
          w_main_we = 1'b1;
        end else if (w_out_xfer) begin
          w_state_nxt = ST_EMPTY;
        end else if (w_in_xfer) begin
          w_skid_we   = 1'b1;
          w_state_nxt = ST_SKID;
        end
      end
      ST_SKID: begin
        if (w_out_xfer) begin
          w_main_we   = 1'b1;
          w_main_d    = w_skid_q;
          w_state_nxt = ST_FULL;
        end
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
    // Flush: the registers clear themselves on clr_n, only the FSM needs forcing.
    if (!clr_n) begin
      w_state_nxt = ST_EMPTY;
    end
  end

  prm_register_sce #(.WIDTH(WIDTH)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_n (clr_n),
    .we    (w_main_we),
    .d     (w_main_d),
    .q     (w_main_q)
  );

  prm_register_sce #(.WIDTH(WIDTH)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_n (clr_n),
    .we    (w_skid_we),
    .d     (in_data),
    .q     (w_skid_q)
  );

  assign out_data = w_main_q;
  assign count    = state_count(r_state);

endmodule

// File: tb/tb_prm_skid_buffer.sv
// Bench for prm_skid_buffer: vector table plus queue scoreboard that tracks
// accepted payloads and checks them as the buffer delivers them.
module tb_prm_skid_buffer;

  logic       clk;
  logic       rst_n;
  logic       clr_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [1:0] count;

  int total = 0;
  int bad   = 0;
  logic [7:0] mq[$];

  typedef struct {
    logic       rn;
    logic       cn;
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       e_ir;
    logic       e_ov;
    logic [1:0] e_cnt;
    logic       chk_data;
    logic [7:0] e_data;
  } vec_t;

  vec_t vecs[$];

  prm_skid_buffer #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_n     (clr_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy,
                              input logic e_ir, input logic e_ov, input logic [1:0] e_cnt,
                              input logic chk_data, input logic [7:0] e_data);
    vec_t v;
    v.rn = 1'b1; v.cn = 1'b1; v.iv = iv; v.id = id; v.ordy = ordy;
    v.e_ir = e_ir; v.e_ov = e_ov; v.e_cnt = e_cnt;
    v.chk_data = chk_data; v.e_data = e_data;
    return v;
  endfunction

  // Called at posedge+1; returns at the next posedge+1 with inputs still held.
  task automatic cycle(input logic rn, input logic cn, input logic iv, input logic [7:0] id,
                       input logic ordy, input bit do_chk);
    logic in_x, out_x, exp_ir, stall;
    logic [7:0] held;
    rst_n = rn; clr_n = cn; in_valid = iv; in_data = id; out_ready = ordy;
    #3;
    exp_ir = (mq.size() < 2) && rn && cn;
    if (do_chk) begin
      chk("in_ready", 32'(in_ready), 32'(exp_ir));
      chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("count", 32'(count), 32'(mq.size()));
      if (mq.size() != 0) chk("sb_data", 32'(out_data), 32'(mq[0]));
    end
    in_x  = iv && exp_ir;
    out_x = (mq.size() != 0) && ordy;
    stall = out_valid && !ordy && rn && cn;
    held  = out_data;
    @(posedge clk);
    if (out_x) void'(mq.pop_front());
    if (!rn || !cn) mq.delete();
    else if (in_x) mq.push_back(id);
    #1;
    if (do_chk && stall) chk("stable", 32'(out_data), 32'(held));
  endtask

  initial begin
    rst_n = 1'b0; clr_n = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    @(posedge clk);
    #1;
    cycle(1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b1);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_cnt", 32'(count), 32'd0);
    chk("rst_ir", 32'(in_ready), 32'd0);

    // streaming: 0x01..0x10 with out_ready high, then drain
    for (int i = 1; i <= 16; i++)
      vecs.push_back(mk(1'b1, 8'(i), 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 8'(i)));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00));
    // backpressure then release
    vecs.push_back(mk(1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 2'd1, 1'b1, 8'hA1));
    vecs.push_back(mk(1'b1, 8'hA2, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 8'hA1));
    vecs.push_back(mk(1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 8'hA1));
    vecs.push_back(mk(1'b1, 8'hA3, 1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 8'hA1));
    vecs.push_back(mk(1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 8'hA2));
    vecs.push_back(mk(1'b1, 8'hA3, 1'b1, 1'b1, 1'b1, 2'd1, 1'b1, 8'hA3));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      cycle(vecs[i].rn, vecs[i].cn, vecs[i].iv, vecs[i].id, vecs[i].ordy, 1'b1);
      chk("vec_ir", 32'(in_ready), 32'(vecs[i].e_ir));
      chk("vec_ov", 32'(out_valid), 32'(vecs[i].e_ov));
      chk("vec_cnt", 32'(count), 32'(vecs[i].e_cnt));
      if (vecs[i].chk_data) chk("vec_data", 32'(out_data), 32'(vecs[i].e_data));
    end

    // flush with two entries buffered
    cycle(1'b1, 1'b1, 1'b1, 8'hB1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b1);
    chk("pre_flush_cnt", 32'(count), 32'd2);
    cycle(1'b1, 1'b0, 1'b1, 8'hB3, 1'b0, 1'b1);
    clr_n = 1'b1; in_valid = 1'b0;
    #1;
    chk("flush_ov", 32'(out_valid), 32'd0);
    chk("flush_cnt", 32'(count), 32'd0);
    chk("flush_ir", 32'(in_ready), 32'd1);
    chk("flush_data", 32'(out_data), 32'd0);
    #1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b1, 1'b1, (i < 3), 8'(8'hC1 + i), 1'b1, 1'b1);
      chk("no_b2", 32'(out_valid && (out_data == 8'hB2)), 32'd0);
    end

    // reset while in SKID with upstream still pushing
    cycle(1'b1, 1'b1, 1'b1, 8'hD1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b1, 8'hD2, 1'b0, 1'b1);
    chk("pre_rst_cnt", 32'(count), 32'd2);
    cycle(1'b0, 1'b1, 1'b1, 8'hD3, 1'b0, 1'b1);
    chk("mrst_ov", 32'(out_valid), 32'd0);
    chk("mrst_data", 32'(out_data), 32'd0);
    chk("mrst_cnt", 32'(count), 32'd0);
    chk("mrst_ir", 32'(in_ready), 32'd0);
    cycle(1'b1, 1'b1, 1'b1, 8'hE1, 1'b0, 1'b1);
    chk("lat_ov", 32'(out_valid), 32'd1);
    chk("lat_data", 32'(out_data), 32'hE1);
    cycle(1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);

    // random traffic with occasional flushes
    for (int i = 0; i < 10000; i++) begin
      cycle(1'b1, ($urandom_range(0, 63) != 0), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
